load_store_arbiter: RTL and testbench

LOAD_STORE_ARBITER -- requirements
Module: load_store_arbiter

---
 rtl/load_store_arbiter.sv | 150 +++++++++++++++
 tb/tb_load_store_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_arbiter.sv
// load_store_arbiter: two-requester arbiter in front of one shared load/store unit.
// A granted operation is latched and held on the LSU until it completes. A
// watchdog can fault the requester early and let the stuck LSU op drain silently.
module load_store_arbiter #(
   parameter int FIXED_PRIORITY = 0,   // 1: requester 0 always wins a tie; 0: round-robin
   parameter int TIMEOUT        = 256  // BUSY cycles before a fault; 0 disables
) (
   input  logic        clk,
   input  logic        rstN,
   // requester 0
   input  logic        reqEnable_0,
   input  logic [31:0] reqAddr_0,
   input  logic [2:0]  reqCommand_0,
   input  logic [3:0]  reqLoadStoreType_0,
   input  logic [3:0]  reqAtomicType_0,
   input  logic [31:0] reqStoreRegValue_0,
   input  logic        reqInvalidateTlb_0,
   output logic        reqDone_0,
   output logic        reqFault_0,
   output logic [31:0] reqResult_0,
   // requester 1
   input  logic        reqEnable_1,
   input  logic [31:0] reqAddr_1,
   input  logic [2:0]  reqCommand_1,
   input  logic [3:0]  reqLoadStoreType_1,
   input  logic [3:0]  reqAtomicType_1,
   input  logic [31:0] reqStoreRegValue_1,
   input  logic        reqInvalidateTlb_1,
   output logic        reqDone_1,
   output logic        reqFault_1,
   output logic [31:0] reqResult_1,
   // shared LSU
   output logic        lsuEnable,
   output logic [31:0] lsuAddr,
   output logic [2:0]  lsuCommand,
   output logic [3:0]  lsuLoadStoreType,
   output logic [3:0]  lsuAtomicType,
   output logic [31:0] lsuStoreRegValue,
   output logic        lsuInvalidateTlb,
   input  logic        lsuDone,
   input  logic        lsuFault,
   input  logic [31:0] lsuResult,
   // status
   output logic        busy,
   output logic        owner
);

   typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

   localparam int OP_W = 76;
   localparam logic        TO_EN  = (TIMEOUT != 0);
   localparam logic [15:0] TO_CMP = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_q, last_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [OP_W-1:0]   op_q, op_d;

   logic              gnt;
   logic              done, fault;
   logic [31:0]       result;
   logic [OP_W-1:0]   op_0, op_1;

   assign op_0 = {reqAddr_0, reqCommand_0, reqLoadStoreType_0, reqAtomicType_0,
                  reqStoreRegValue_0, reqInvalidateTlb_0};
   assign op_1 = {reqAddr_1, reqCommand_1, reqLoadStoreType_1, reqAtomicType_1,
                  reqStoreRegValue_1, reqInvalidateTlb_1};

   // Tie-break: fixed picks 0, round-robin picks whoever was not granted last.
   assign gnt = (reqEnable_0 && reqEnable_1) ? ((FIXED_PRIORITY != 0) ? 1'b0 : ~last_q)
                                             : reqEnable_1;

   // Next-state, grant latching, watchdog and completion signalling.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      done    = 1'b0;
      fault   = 1'b0;
      result  = 32'd0;
      unique case (state_q)
         IDLE: begin
            if (reqEnable_0 || reqEnable_1) begin
               state_d = BUSY;
               owner_d = gnt;
               last_d  = gnt;
               cnt_d   = 16'd0;
               op_d    = gnt ? op_1 : op_0;
            end
         end
         BUSY: begin
            if (lsuDone) begin
               // A real completion beats a watchdog firing in the same cycle.
               done    = 1'b1;
               fault   = lsuFault;
               result  = lsuResult;
               state_d = IDLE;
            end else begin
               if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
               if (TO_EN && (cnt_q == TO_CMP)) begin
                  done    = 1'b1;
                  fault   = 1'b1;
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Requester already got its fault; swallow the late completion.
            if (lsuDone) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and latched-operation registers.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         cnt_q   <= 16'd0;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign lsuEnable = busy;
   assign owner     = owner_q;

   // LSU fields come only from the latch, zeroed while idle.
   assign {lsuAddr, lsuCommand, lsuLoadStoreType, lsuAtomicType,
           lsuStoreRegValue, lsuInvalidateTlb} = busy ? op_q : '0;

   assign reqDone_0   = done  & ~owner_q;
   assign reqFault_0  = fault & ~owner_q;
   assign reqResult_0 = owner_q ? 32'd0 : result;
   assign reqDone_1   = done  &  owner_q;
   assign reqFault_1  = fault &  owner_q;
   assign reqResult_1 = owner_q ? result : 32'd0;

endmodule

// File: tb/tb_load_store_arbiter.sv
// Directed bench: a round-robin/TIMEOUT=4 arbiter and a fixed-priority/no-timeout
// arbiter share all inputs so their differing behaviour is checked side by side.
module tb_load_store_arbiter;

   logic        clk = 1'b0;
   logic        rstN;
   logic        reqEnable_0, reqEnable_1;
   logic [31:0] reqAddr_0, reqAddr_1;
   logic [2:0]  reqCommand_0, reqCommand_1;
   logic [3:0]  reqLoadStoreType_0, reqLoadStoreType_1;
   logic [3:0]  reqAtomicType_0, reqAtomicType_1;
   logic [31:0] reqStoreRegValue_0, reqStoreRegValue_1;
   logic        reqInvalidateTlb_0, reqInvalidateTlb_1;
   logic        lsuDone, lsuFault;
   logic [31:0] lsuResult;

   logic        r_reqDone_0, r_reqFault_0, r_reqDone_1, r_reqFault_1;
   logic [31:0] r_reqResult_0, r_reqResult_1;
   logic        r_lsuEnable, r_lsuInvalidateTlb, r_busy, r_owner;
   logic [31:0] r_lsuAddr, r_lsuStoreRegValue;
   logic [2:0]  r_lsuCommand;
   logic [3:0]  r_lsuLoadStoreType, r_lsuAtomicType;

   logic        f_reqDone_0, f_reqFault_0, f_reqDone_1, f_reqFault_1;
   logic [31:0] f_reqResult_0, f_reqResult_1;
   logic        f_lsuEnable, f_lsuInvalidateTlb, f_busy, f_owner;
   logic [31:0] f_lsuAddr, f_lsuStoreRegValue;
   logic [2:0]  f_lsuCommand;
   logic [3:0]  f_lsuLoadStoreType, f_lsuAtomicType;

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   load_store_arbiter #(.FIXED_PRIORITY(0), .TIMEOUT(4)) dut_rr (
      .clk(clk), .rstN(rstN),
      .reqEnable_0(reqEnable_0), .reqAddr_0(reqAddr_0), .reqCommand_0(reqCommand_0),
      .reqLoadStoreType_0(reqLoadStoreType_0), .reqAtomicType_0(reqAtomicType_0),
      .reqStoreRegValue_0(reqStoreRegValue_0), .reqInvalidateTlb_0(reqInvalidateTlb_0),
      .reqDone_0(r_reqDone_0), .reqFault_0(r_reqFault_0), .reqResult_0(r_reqResult_0),
      .reqEnable_1(reqEnable_1), .reqAddr_1(reqAddr_1), .reqCommand_1(reqCommand_1),
      .reqLoadStoreType_1(reqLoadStoreType_1), .reqAtomicType_1(reqAtomicType_1),
      .reqStoreRegValue_1(reqStoreRegValue_1), .reqInvalidateTlb_1(reqInvalidateTlb_1),
      .reqDone_1(r_reqDone_1), .reqFault_1(r_reqFault_1), .reqResult_1(r_reqResult_1),
      .lsuEnable(r_lsuEnable), .lsuAddr(r_lsuAddr), .lsuCommand(r_lsuCommand),
      .lsuLoadStoreType(r_lsuLoadStoreType), .lsuAtomicType(r_lsuAtomicType),
      .lsuStoreRegValue(r_lsuStoreRegValue), .lsuInvalidateTlb(r_lsuInvalidateTlb),
      .lsuDone(lsuDone), .lsuFault(lsuFault), .lsuResult(lsuResult),
      .busy(r_busy), .owner(r_owner)
   );

   load_store_arbiter #(.FIXED_PRIORITY(1), .TIMEOUT(0)) dut_fp (
      .clk(clk), .rstN(rstN),
      .reqEnable_0(reqEnable_0), .reqAddr_0(reqAddr_0), .reqCommand_0(reqCommand_0),
      .reqLoadStoreType_0(reqLoadStoreType_0), .reqAtomicType_0(reqAtomicType_0),
      .reqStoreRegValue_0(reqStoreRegValue_0), .reqInvalidateTlb_0(reqInvalidateTlb_0),
      .reqDone_0(f_reqDone_0), .reqFault_0(f_reqFault_0), .reqResult_0(f_reqResult_0),
      .reqEnable_1(reqEnable_1), .reqAddr_1(reqAddr_1), .reqCommand_1(reqCommand_1),
      .reqLoadStoreType_1(reqLoadStoreType_1), .reqAtomicType_1(reqAtomicType_1),
      .reqStoreRegValue_1(reqStoreRegValue_1), .reqInvalidateTlb_1(reqInvalidateTlb_1),
      .reqDone_1(f_reqDone_1), .reqFault_1(f_reqFault_1), .reqResult_1(f_reqResult_1),
      .lsuEnable(f_lsuEnable), .lsuAddr(f_lsuAddr), .lsuCommand(f_lsuCommand),
      .lsuLoadStoreType(f_lsuLoadStoreType), .lsuAtomicType(f_lsuAtomicType),
      .lsuStoreRegValue(f_lsuStoreRegValue), .lsuInvalidateTlb(f_lsuInvalidateTlb),
      .lsuDone(lsuDone), .lsuFault(lsuFault), .lsuResult(lsuResult),
      .busy(f_busy), .owner(f_owner)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rstN = 1'b0;
      reqEnable_0 = 0; reqAddr_0 = 0; reqCommand_0 = 0; reqLoadStoreType_0 = 0;
      reqAtomicType_0 = 0; reqStoreRegValue_0 = 0; reqInvalidateTlb_0 = 0;
      reqEnable_1 = 0; reqAddr_1 = 0; reqCommand_1 = 0; reqLoadStoreType_1 = 0;
      reqAtomicType_1 = 0; reqStoreRegValue_1 = 0; reqInvalidateTlb_1 = 0;
      lsuDone = 0; lsuFault = 0; lsuResult = 0;
      #3;
      chk("rst_busy", 32'(r_busy), 32'd0);
      chk("rst_lsuEnable", 32'(r_lsuEnable), 32'd0);
      chk("rst_owner", 32'(r_owner), 32'd0);
      chk("rst_done0", 32'(r_reqDone_0), 32'd0);
      #9 rstN = 1'b1;

      // ---- single load ----
      cyc();
      reqEnable_0 = 1; reqAddr_0 = 32'h1000; reqCommand_0 = 3'd1;
      reqLoadStoreType_0 = 4'h2; reqAtomicType_0 = 4'h5;
      reqStoreRegValue_0 = 32'h55AA55AA; reqInvalidateTlb_0 = 1;
      #1;
      chk("idle_lsuEnable", 32'(r_lsuEnable), 32'd0);
      chk("idle_lsuAddr", r_lsuAddr, 32'd0);
      cyc();
      #1;
      chk("t1_lsuEnable", 32'(r_lsuEnable), 32'd1);
      chk("t1_lsuAddr", r_lsuAddr, 32'h1000);
      chk("t1_lsuCommand", 32'(r_lsuCommand), 32'd1);
      chk("t1_lsuLsType", 32'(r_lsuLoadStoreType), 32'h2);
      chk("t1_lsuAtomic", 32'(r_lsuAtomicType), 32'h5);
      chk("t1_lsuStore", r_lsuStoreRegValue, 32'h55AA55AA);
      chk("t1_lsuInvTlb", 32'(r_lsuInvalidateTlb), 32'd1);
      chk("t1_busy", 32'(r_busy), 32'd1);
      chk("t1_done0_early", 32'(r_reqDone_0), 32'd0);
      cyc();
      cyc();
      lsuDone = 1; lsuResult = 32'hDEADBEEF;
      #1;
      chk("t3_done0", 32'(r_reqDone_0), 32'd1);
      chk("t3_result0", r_reqResult_0, 32'hDEADBEEF);
      chk("t3_fault0", 32'(r_reqFault_0), 32'd0);
      chk("t3_done1", 32'(r_reqDone_1), 32'd0);
      chk("t3_result1", r_reqResult_1, 32'd0);
      cyc();
      lsuDone = 0; reqEnable_0 = 0;
      #1;
      chk("t4_busy", 32'(r_busy), 32'd0);
      chk("t4_lsuEnable", 32'(r_lsuEnable), 32'd0);
      chk("t4_lsuAddr", r_lsuAddr, 32'd0);
      chk("t4_result0", r_reqResult_0, 32'd0);

      // ---- round-robin vs fixed priority, both requesting ----
      rstN = 0; #2; rstN = 1;
      reqEnable_0 = 1; reqAddr_0 = 32'hA0; reqEnable_1 = 1; reqAddr_1 = 32'hB0;
      reqInvalidateTlb_0 = 0;
      for (int k = 0; k < 4; k++) begin
         cyc();
         #1;
         chk("rr_owner", 32'(r_owner), 32'(k % 2));
         chk("rr_lsuAddr", r_lsuAddr, (k % 2) ? 32'hB0 : 32'hA0);
         chk("fp_owner", 32'(f_owner), 32'd0);
         if (k == 0) begin
            // non-owner churn must not disturb the latched operation
            reqEnable_1 = 0; reqAddr_1 = 32'hFFFF;
            #1;
            chk("nonowner_lsuAddr", r_lsuAddr, 32'hA0);
            reqEnable_1 = 1; reqAddr_1 = 32'hB0;
         end
         lsuDone = 1; lsuResult = 32'h100 + 32'(k);
         #1;
         chk("rr_done_own", 32'((k % 2) ? r_reqDone_1 : r_reqDone_0), 32'd1);
         chk("rr_done_other", 32'((k % 2) ? r_reqDone_0 : r_reqDone_1), 32'd0);
         chk("rr_result_own", (k % 2) ? r_reqResult_1 : r_reqResult_0, 32'h100 + 32'(k));
         chk("rr_result_other", (k % 2) ? r_reqResult_0 : r_reqResult_1, 32'd0);
         chk("fp_done0", 32'(f_reqDone_0), 32'd1);
         cyc();
         lsuDone = 0;
      end
      reqEnable_0 = 0;
      cyc();
      #1;
      chk("fp_owner_alone1", 32'(f_owner), 32'd1);
      chk("rr_owner_alone1", 32'(r_owner), 32'd1);
      lsuDone = 1;
      #1;
      chk("fp_done1", 32'(f_reqDone_1), 32'd1);
      chk("fp_done0_idle", 32'(f_reqDone_0), 32'd0);
      cyc();
      lsuDone = 0; reqEnable_1 = 0;

      // ---- timeout (rr) vs timeout disabled (fp) ----
      reqEnable_0 = 1; lsuResult = 32'h77;
      for (int i = 1; i <= 4; i++) begin
         cyc();
         #1;
         chk("to_done0", 32'(r_reqDone_0), (i == 4) ? 32'd1 : 32'd0);
         chk("to_fault0", 32'(r_reqFault_0), (i == 4) ? 32'd1 : 32'd0);
         chk("to_result0", r_reqResult_0, 32'd0);
         chk("to_fp_done0", 32'(f_reqDone_0), 32'd0);
      end
      cyc();
      #1;
      chk("drain_busy", 32'(r_busy), 32'd1);
      chk("drain_lsuEnable", 32'(r_lsuEnable), 32'd1);
      chk("drain_lsuAddr", r_lsuAddr, 32'hA0);
      chk("drain_done0", 32'(r_reqDone_0), 32'd0);
      cyc();
      lsuDone = 1; lsuFault = 1; lsuResult = 32'hCAFE0001;
      #1;
      chk("drain_end_done0", 32'(r_reqDone_0), 32'd0);
      chk("drain_end_fault0", 32'(r_reqFault_0), 32'd0);
      chk("drain_end_result0", r_reqResult_0, 32'd0);
      chk("fp_late_done0", 32'(f_reqDone_0), 32'd1);
      chk("fp_late_fault0", 32'(f_reqFault_0), 32'd1);
      chk("fp_late_result0", f_reqResult_0, 32'hCAFE0001);
      cyc();
      lsuDone = 0; lsuFault = 0; reqEnable_0 = 0;
      #1;
      chk("post_drain_busy", 32'(r_busy), 32'd0);
      chk("fp_post_busy", 32'(f_busy), 32'd0);

      // ---- completion races the watchdog ----
      reqEnable_0 = 1;
      for (int i = 1; i <= 3; i++) cyc();
      cyc();
      lsuDone = 1; lsuFault = 0; lsuResult = 32'h12345678;
      #1;
      chk("race_done0", 32'(r_reqDone_0), 32'd1);
      chk("race_fault0", 32'(r_reqFault_0), 32'd0);
      chk("race_result0", r_reqResult_0, 32'h12345678);
      cyc();
      lsuDone = 0; reqEnable_0 = 0;
      #1;
      chk("race_no_drain", 32'(r_busy), 32'd0);

      // ---- asynchronous reset mid-operation ----
      reqEnable_1 = 1;
      cyc();
      #1;
      chk("ar_owner1", 32'(r_owner), 32'd1);
      chk("ar_busy_pre", 32'(r_busy), 32'd1);
      #1 rstN = 0;
      #1;
      chk("ar_lsuEnable", 32'(r_lsuEnable), 32'd0);
      chk("ar_busy", 32'(r_busy), 32'd0);
      chk("ar_owner", 32'(r_owner), 32'd0);
      chk("ar_lsuAddr", r_lsuAddr, 32'd0);
      chk("ar_done1", 32'(r_reqDone_1), 32'd0);
      chk("ar_fp_busy", 32'(f_busy), 32'd0);
      #1 rstN = 1;
      reqEnable_0 = 1;
      cyc();
      #1;
      chk("ar_regrant_owner", 32'(r_owner), 32'd0);
      chk("ar_regrant_lsuAddr", r_lsuAddr, 32'hA0);
      lsuDone = 1; lsuResult = 32'h5;
      #1;
      chk("ar_regrant_done0", 32'(r_reqDone_0), 32'd1);
      chk("ar_regrant_result0", r_reqResult_0, 32'h5);
      cyc();
      lsuDone = 0; reqEnable_0 = 0; reqEnable_1 = 0;

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
